// File: rtl/cmp_result_monitor_pkg.sv
// cmp_result_monitor_pkg
// Shared definitions for the comparator result monitor: the state encoding,
// the default operand and counter widths, and a one-hot helper used by the
// flag checker.
package cmp_result_monitor_pkg;

    localparam int N_DEF     = 9;
    localparam int CNT_W_DEF = 8;

    // ACCUM collects samples of a frame; REPORT holds the frame result.
    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } mon_state_e;

    // True when exactly one bit of a 3-bit flag vector is set.
    function automatic logic is_onehot3(input logic [2:0] flags);
        logic result;
        case (flags)
            3'b001:  result = 1'b1;
            3'b010:  result = 1'b1;
            3'b100:  result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/cmp_result_monitor_if.sv
// cmp_result_monitor_if
// Bundles the sample input handshake (in_valid/in_ready/in_last, operands
// a/b and the comparator flags under check) and the frame result handshake
// (res_valid/res_ready, outcome counters and max_a).
//   master : the side producing samples and consuming results
//   slave  : the monitor itself
interface cmp_result_monitor_if
    import cmp_result_monitor_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             lesser;
    logic             greater;
    logic             equal;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [N-1:0]     max_a;

    modport master (
        output in_valid, in_last, a, b, lesser, greater, equal, res_ready,
        input  in_ready, res_valid, lt_cnt, gt_cnt, eq_cnt, err_cnt, max_a
    );

    modport slave (
        input  in_valid, in_last, a, b, lesser, greater, equal, res_ready,
        output in_ready, res_valid, lt_cnt, gt_cnt, eq_cnt, err_cnt, max_a
    );

endinterface

// File: rtl/cmp_result_monitor_sat_counter.sv
// sat_counter
// Registered CNT_W-bit up-counter that sticks at its all-ones value.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count up by one (ignored once saturated)
//   clr      : clear to zero; wins over inc
//   cnt      : current count
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cmp_result_monitor.sv
// cmp_result_monitor
// Checks a comparator's lesser/greater/equal flags against its own operands
// over a frame of samples and reports per-outcome counts, an error count and
// the largest operand a seen in the frame.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cmp_result_monitor_if.slave (sample input and result output)
// A frame ends on the accepted sample with in_last=1; the result is then held
// until the consumer takes it, during which no samples are accepted.
module cmp_result_monitor
    import cmp_result_monitor_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    cmp_result_monitor_if.slave   bus
);

    mon_state_e   state_d;
    mon_state_e   state_q;
    logic [N-1:0] max_a_d;
    logic [N-1:0] max_a_q;

    logic       accept_s;
    logic       clr_s;
    logic [2:0] exp_flags_s;
    logic [2:0] got_flags_s;
    logic       correct_s;
    logic       inc_lt_s;
    logic       inc_gt_s;
    logic       inc_eq_s;
    logic       inc_err_s;

    // Sample acceptance, result hand-off and flag check.
    // The expected vector is always one-hot, so an exact match already
    // implies one-hot; the explicit one-hot test keeps the intent visible.
    always_comb begin
        accept_s    = bus.in_valid && (state_q == ACCUM);
        clr_s       = bus.res_ready && (state_q == REPORT);
        exp_flags_s = {(bus.a < bus.b), (bus.a > bus.b), (bus.a == bus.b)};
        got_flags_s = {bus.lesser, bus.greater, bus.equal};
        correct_s   = is_onehot3(got_flags_s) && (got_flags_s == exp_flags_s);
        inc_lt_s    = accept_s && correct_s && bus.lesser;
        inc_gt_s    = accept_s && correct_s && bus.greater;
        inc_eq_s    = accept_s && correct_s && bus.equal;
        inc_err_s   = accept_s && !correct_s;
    end

    // Next state and running maximum of a.
    always_comb begin
        state_d = state_q;
        max_a_d = max_a_q;
        case (state_q)
            ACCUM: begin
                if (accept_s && (bus.a > max_a_q)) begin
                    max_a_d = bus.a;
                end else begin
                    max_a_d = max_a_q;
                end
                if (accept_s && bus.in_last) begin
                    state_d = REPORT;
                end else begin
                    state_d = ACCUM;
                end
            end
            REPORT: begin
                if (clr_s) begin
                    state_d = ACCUM;
                    max_a_d = {N{1'b0}};
                end else begin
                    state_d = REPORT;
                    max_a_d = max_a_q;
                end
            end
            default: begin
                state_d = ACCUM;
                max_a_d = {N{1'b0}};
            end
        endcase
    end

    // State and max_a registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            max_a_q <= {N{1'b0}};
        end else begin
            state_q <= state_d;
            max_a_q <= max_a_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk (clk), .rst (rst), .inc (inc_lt_s),  .clr (clr_s), .cnt (bus.lt_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk (clk), .rst (rst), .inc (inc_gt_s),  .clr (clr_s), .cnt (bus.gt_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk (clk), .rst (rst), .inc (inc_eq_s),  .clr (clr_s), .cnt (bus.eq_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (clk), .rst (rst), .inc (inc_err_s), .clr (clr_s), .cnt (bus.err_cnt)
    );

    // Handshake outputs come straight from the state register.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.res_valid = (state_q == REPORT);
    assign bus.max_a     = max_a_q;

endmodule

// File: doc/cmp_result_monitor.md
CMP_RESULT_MONITOR -- requirements
Module: cmp_result_monitor

Interface
REQ-001 Parameter N, default 9: operand width; equals the comparator operand width.
REQ-002 Parameter CNT_W, default 8: width of each per-frame counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; port clk, input, 1, rising-edge clock.
REQ-004 rst, input, 1: asynchronous, active-high reset.
REQ-005 in_valid, input, 1: sample present on a/b/lesser/greater/equal.
REQ-006 in_ready, output, 1: monitor accepts a sample this cycle.
REQ-007 in_last, input, 1: accepted sample is the final one of its frame.
REQ-008 a, input, N: comparator operand a (unsigned).
REQ-009 b, input, N: comparator operand b (unsigned).
REQ-010 lesser / greater / equal, input, 1 each: comparator flags under check.
REQ-011 res_valid, output, 1: frame result registers valid.
REQ-012 res_ready, input, 1: consumer takes the result.
REQ-013 lt_cnt / gt_cnt / eq_cnt, output, CNT_W each: count of correct samples per outcome.
REQ-014 err_cnt, output, CNT_W: count of samples whose flags are wrong.
REQ-015 max_a, output, N: largest a among accepted samples of the frame.

Function
REQ-016 The state machine SHALL have two states: ACCUM (in_ready=1, res_valid=0) and REPORT (in_ready=0, res_valid=1).
REQ-017 A sample SHALL be accepted only when in_valid and in_ready are both 1 on a rising clk edge.
REQ-018 An accepted sample SHALL be correct only if its flags are exactly one-hot and equal {a<b, a>b, a==b}.
REQ-019 A correct sample SHALL increment exactly one of lt_cnt, gt_cnt or eq_cnt.
REQ-020 An incorrect sample (not one-hot, or inconsistent with a/b) SHALL increment only err_cnt.
REQ-021 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-022 max_a SHALL update on every accepted sample, correct or not: max_a <= max(max_a, a).
REQ-023 Accepting a sample with in_last=1 SHALL fold that sample into the results and enter REPORT on the same edge, so res_valid rises the next cycle (latency 1).
REQ-024 In REPORT all result outputs SHALL hold stable until res_valid and res_ready are both 1.
REQ-025 On the res_valid & res_ready edge: counters and max_a clear to 0, state returns to ACCUM, and in_ready=1 the following cycle.
REQ-026 While in REPORT, input samples SHALL NOT be accepted, and in_valid, a, b and the flags SHALL be ignored.
REQ-027 A frame may contain a single sample (in_last on its first beat); it SHALL report that one sample.
REQ-028 res_ready asserted during ACCUM SHALL have no effect.

Reset
REQ-029 Asserting rst at any time, including mid-frame or during REPORT, SHALL immediately force state ACCUM, all counters 0, max_a 0, res_valid 0 and in_ready 1.
REQ-030 A partial frame interrupted by rst SHALL be discarded and never reported.
REQ-031 After rst deasserts, the first rising clk edge SHALL be able to accept a sample.

Structure
REQ-032 A shared package SHALL hold the state encoding (ACCUM, REPORT) and the default N and CNT_W constants.
REQ-033 A sub-module sat_counter (CNT_W wide, inc/clr inputs, saturating) SHALL be instantiated four times.
REQ-034 The flag-check logic SHALL remain combinational inside cmp_result_monitor, with no instantiated comparator.

Verification
REQ-035 Sample 1: a=5, b=9, lesser=1; sample 2: a=9, b=9, equal=1; sample 3: a=300, b=2, greater=1, in_last=1 -> next cycle res_valid=1, lt=1, eq=1, gt=1, err=0, max_a=300.
REQ-036 a=7, b=3 with lesser=1 -> err_cnt=1 and lt_cnt=0; a=4, b=4 with equal=1 and greater=1 -> err_cnt=2 at report.
REQ-037 300 correct lesser samples in one frame with CNT_W=8 -> lt_cnt=255 at report.
REQ-038 Hold res_ready=0 for 5 cycles in REPORT while driving in_valid=1 -> results unchanged and in_ready=0 throughout; then res_ready=1 for 1 cycle -> counters 0 and in_ready=1 the next cycle.
REQ-039 Assert rst after 3 samples of a frame -> all outputs 0 and no res_valid; the next frame reports only its own samples.
REQ-040 Single-sample frame a=511, b=0, greater=1, in_last=1 -> gt=1, max_a=511.
